// File: rtl/fifo_pkg.sv
// Shared types and helpers for the byte FIFO and the word packer that drains it.
package fifo_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {FILL, HOLD} packer_state_e;

  // Low 'count' bits set, clipped to word_bytes lanes (max 8).
  function automatic logic [7:0] keep_mask(input logic [3:0] count, input int word_bytes);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if ((i < int'(count)) && (i < word_bytes)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo.sv
// Byte FIFO with registered read data: read_data is valid the cycle after read_ctrl.
module fifo
  import fifo_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  write_ctrl,
  input  byte_t write_data,
  input  logic  read_ctrl,
  output byte_t read_data,
  output logic  is_empty,
  output logic  is_full
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  byte_t            mem_q [ENTRIES];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  byte_t            read_data_q;
  logic             wr_fire, rd_fire;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_W'(ENTRIES));
  assign wr_fire   = write_ctrl && !is_full;
  assign rd_fire   = read_ctrl && !is_empty;
  assign read_data = read_data_q;

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      read_data_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_fire) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        read_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains the byte FIFO and packs WORD_BYTES bytes little-endian into a valid/ready word,
// with flush-driven partial words and a sticky byte-accounting error flag.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_is_empty,
  input  logic [BYTE_W-1:0]            fifo_read_data,
  output logic                         fifo_read_ctrl,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BYTE_W*WORD_BYTES-1:0] out_data,
  output logic [WORD_BYTES-1:0]        out_keep,
  output logic                         busy,
  output logic                         error
);

  localparam int LANE_LOG2 = $clog2(WORD_BYTES) + 1;
  localparam int OCC_W     = LANE_LOG2 + 1;

  packer_state_e         state_q, state_d;
  logic [LANE_LOG2-1:0]  fill_count_q, fill_count_d;
  logic                  rd_pending_q;
  logic                  flush_pending_q, flush_pending_d;
  logic [WORD_BYTES-1:0] keep_q, keep_d;
  byte_t                 lanes_q [WORD_BYTES];
  logic [31:0]           bytes_popped_q, bytes_emitted_q;
  logic                  error_q;

  logic                  handshake, capture_full, flush_emit;
  logic [OCC_W-1:0]      occupancy;
  logic [7:0]            flush_mask;
  logic [LANE_LOG2:0]    keep_pop;

  // An in-flight byte already owns a lane, so it counts toward the word.
  assign occupancy      = OCC_W'(fill_count_q) + OCC_W'(rd_pending_q);
  assign fifo_read_ctrl = (state_q == FILL) && !fifo_is_empty && !flush_pending_q &&
                          (occupancy < OCC_W'(WORD_BYTES));

  assign handshake    = (state_q == HOLD) && out_ready;
  assign capture_full = rd_pending_q && (fill_count_q == LANE_LOG2'(WORD_BYTES - 1));
  assign flush_emit   = (state_q == FILL) && flush_pending_q && !rd_pending_q &&
                        (fill_count_q != '0);
  assign flush_mask   = keep_mask(4'(fill_count_q), WORD_BYTES);

  assign out_valid = (state_q == HOLD);
  assign out_keep  = keep_q;
  assign busy      = (fill_count_q != '0) || rd_pending_q || flush_pending_q;
  assign error     = error_q;

  always_comb begin
    state_d         = state_q;
    fill_count_d    = fill_count_q;
    keep_d          = keep_q;
    flush_pending_d = flush_pending_q;
    case (state_q)
      FILL: begin
        if (flush) flush_pending_d = 1'b1;
        if (rd_pending_q) fill_count_d = fill_count_q + LANE_LOG2'(1);
        if (capture_full) begin
          state_d = HOLD;
          keep_d  = '1;
        end else if (flush_emit) begin
          state_d = HOLD;
          keep_d  = flush_mask[WORD_BYTES-1:0];
        end else if (flush_pending_q && !rd_pending_q && (fill_count_q == '0)) begin
          // Nothing buffered: the flush completes without producing a word.
          flush_pending_d = 1'b0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d         = FILL;
          fill_count_d    = '0;
          keep_d          = '0;
          flush_pending_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      keep_pop = keep_pop + (LANE_LOG2 + 1)'(keep_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FILL;
      fill_count_q    <= '0;
      rd_pending_q    <= 1'b0;
      flush_pending_q <= 1'b0;
      keep_q          <= '0;
      bytes_popped_q  <= '0;
      bytes_emitted_q <= '0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      fill_count_q    <= fill_count_d;
      rd_pending_q    <= fifo_read_ctrl;
      flush_pending_q <= flush_pending_d;
      keep_q          <= keep_d;
      bytes_popped_q  <= bytes_popped_q + 32'(fifo_read_ctrl);
      if (handshake) bytes_emitted_q <= bytes_emitted_q + 32'(keep_pop);
      error_q <= error_q | (bytes_emitted_q > bytes_popped_q);
    end
  end

  // Lanes are cleared on handshake so unused lanes of a partial word read as zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (rst || handshake) begin
        lanes_q[i] <= '0;
      end else if (rd_pending_q && (fill_count_q == LANE_LOG2'(i))) begin
        lanes_q[i] <= fifo_read_data;
      end
    end
  end

  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_pack
    assign out_data[BYTE_W*gi +: BYTE_W] = lanes_q[gi];
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for the fifo + fifo_word_packer pair: vector table plus corner-case sequences.
module tb_fifo_word_packer;

  localparam int WB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        fifo_full, fifo_empty, rd_ctrl;
  logic [7:0]  rd_data;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid, busy, error;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  always #5 clk = ~clk;

  fifo #(.ENTRIES(4)) u_fifo (
    .clk(clk), .rst(rst),
    .write_ctrl(wr_en), .write_data(wr_data),
    .read_ctrl(rd_ctrl), .read_data(rd_data),
    .is_empty(fifo_empty), .is_full(fifo_full)
  );

  fifo_word_packer #(.WORD_BYTES(WB)) dut (
    .clk(clk), .rst(rst),
    .fifo_is_empty(fifo_empty), .fifo_read_data(rd_data), .fifo_read_ctrl(rd_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep),
    .busy(busy), .error(error)
  );

  typedef struct {
    int          n;
    logic [31:0] bytes;
    bit          do_flush;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t vecs [6];

  int total = 0, bad = 0;
  int ncyc = 0, first_rd = -1, first_valid = -1, reads_seen = 0, empty_rd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and record what the pair is doing in that cycle.
  task automatic step();
    @(negedge clk);
    ncyc++;
    if (rd_ctrl) begin
      reads_seen++;
      if (first_rd < 0) first_rd = ncyc;
      if (fifo_empty) empty_rd++;
    end
    if (out_valid && first_valid < 0) first_valid = ncyc;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = out_valid;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = out_valid;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    bit ok;
    int hold_bad, rd_bad, rs;

    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'b1111};
    vecs[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'b0011};
    vecs[2] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'b0001};
    vecs[3] = '{3, 32'h00C3C2C1, 1'b1, 32'h00C3C2C1, 4'b0111};
    vecs[4] = '{4, 32'hEFBEADDE, 1'b0, 32'hEFBEADDE, 4'b1111};
    vecs[5] = '{4, 32'hFF00FF00, 1'b0, 32'hFF00FF00, 4'b1111};

    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdctrl", rd_ctrl, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_rdctrl", rd_ctrl, 0);

    for (int v = 0; v < 6; v++) begin
      first_rd = -1;
      first_valid = -1;
      for (int k = 0; k < vecs[v].n; k++) push(vecs[v].bytes[8*k +: 8]);
      if (vecs[v].do_flush) begin
        repeat (3) step();
        pulse_flush();
      end
      wait_valid(20, ok);
      chk($sformatf("v%0d_valid", v), ok, 1);
      chk($sformatf("v%0d_data", v), out_data, vecs[v].exp_data);
      chk($sformatf("v%0d_keep", v), out_keep, vecs[v].exp_keep);
      if (!vecs[v].do_flush) chk($sformatf("v%0d_latency", v), 64'(first_valid - first_rd), WB + 1);
      $display("vec %0d: data=%h keep=%b", v, out_data, out_keep);
      step();
      chk($sformatf("v%0d_busy_after", v), busy, 0);
      chk($sformatf("v%0d_valid_after", v), out_valid, 0);
    end

    // Backpressure: first word must hold with no pops, second follows on release.
    out_ready = 1'b0;
    for (int b = 1; b <= 8; b++) push(8'(b));
    wait_valid(20, ok);
    chk("bp_valid", ok, 1);
    hold_bad = 0;
    rd_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid || out_data !== 32'h04030201 || out_keep !== 4'b1111) hold_bad++;
      if (rd_ctrl) rd_bad++;
      step();
    end
    chk("bp_word1", out_data, 32'h04030201);
    chk("bp_hold", hold_bad, 0);
    chk("bp_noread", rd_bad, 0);
    $display("backpressure word1: data=%h keep=%b", out_data, out_keep);
    out_ready = 1'b1;
    step();
    wait_valid(20, ok);
    chk("bp_valid2", ok, 1);
    chk("bp_word2", out_data, 32'h08070605);
    chk("bp_keep2", out_keep, 4'b1111);
    $display("backpressure word2: data=%h keep=%b", out_data, out_keep);
    step();
    chk("bp_busy_after", busy, 0);

    // Flush issued in the same cycle as the third read.
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("fir_rd3_issued", rd_ctrl, 1);
    pulse_flush();
    wait_valid(20, ok);
    chk("fir_valid", ok, 1);
    chk("fir_data", out_data, 32'h00030201);
    chk("fir_keep", out_keep, 4'b0111);
    $display("flush in-flight: data=%h keep=%b", out_data, out_keep);
    step();
    chk("fir_busy_after", busy, 0);

    // FIFO runs dry after one byte: packer waits, then flushes it out.
    rs = reads_seen;
    first_valid = -1;
    push(8'h77);
    repeat (10) step();
    chk("stall_reads", reads_seen - rs, 1);
    chk("stall_no_valid", 64'(first_valid == -1), 1);
    chk("stall_busy", busy, 1);
    pulse_flush();
    wait_valid(20, ok);
    chk("stall_flush_valid", ok, 1);
    chk("stall_flush_data", out_data, 32'h00000077);
    chk("stall_flush_keep", out_keep, 4'b0001);
    $display("stall flush: data=%h keep=%b", out_data, out_keep);
    step();

    // Flush with nothing buffered produces no word.
    pulse_flush();
    chk("eflush_pending", busy, 1);
    step();
    chk("eflush_cleared", busy, 0);
    first_valid = -1;
    repeat (5) step();
    chk("eflush_no_word", 64'(first_valid == -1), 1);
    $display("empty flush: busy=%b valid=%b", busy, out_valid);

    // Reset mid-word discards the partial word.
    push(8'hA1);
    push(8'hA2);
    repeat (2) step();
    chk("mid_busy_before", busy, 1);
    chk("mid_data_before", out_data, 32'h0000A2A1);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_keep", out_keep, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdctrl", rd_ctrl, 0);
    rst = 1'b0;
    step();
    first_rd = -1;
    first_valid = -1;
    for (int b = 0; b < 4; b++) push(8'h10 + 8'(b));
    wait_valid(20, ok);
    chk("post_rst_valid", ok, 1);
    chk("post_rst_data", out_data, 32'h13121110);
    chk("post_rst_keep", out_keep, 4'b1111);
    chk("post_rst_latency", 64'(first_valid - first_rd), WB + 1);
    $display("post reset: data=%h keep=%b", out_data, out_keep);
    step();

    repeat (3) step();
    chk("error_final", error, 0);
    chk("no_read_when_empty", empty_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
